muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide responder serving the CPU's HI/LO operations.
- Executes signed and unsigned MULT/DIV iteratively, one bit per clock, under a start/busy/done handshake.
- Holds its results in HI/LO registers, so the datapath does not need a combinational 32x32 multiplier or divider in the critical path.
- The issuing stage raises start and stalls on busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CW, 5, iteration counter width; must satisfy 2^CW >= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request strobe; sampled only in IDLE
- op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed)
- a  input  WIDTH  multiplicand / dividend
- b  input  WIDTH  multiplier / divisor
- busy  output  1  high in CALC and SIGN
- done  output  1  one-cycle pulse when hi/lo are valid
- hi  output  WIDTH  product[2W-1:W] or remainder
- lo  output  WIDTH  product[W-1:0] or quotient
- div_zero  output  1  last divide had b==0; valid with done, held until the next accepted start

Behaviour:
Reset:
- rst_n low asynchronously forces state=IDLE and counter=0.
- busy=0, done=0, hi=0, lo=0, div_zero=0.
- Applies mid-operation too: the operation is abandoned and no done is issued.

State machine:
- IDLE
  - At a clock edge with start=1, capture op, sign flags, |a| and |b|, clear the counter, go to CALC.
  - For unsigned ops, |x| is x.
  - For signed ops, |x| is the two's-complement magnitude; 0x80000000 maps to 0x80000000 unsigned.
- CALC
  - One iteration per edge. Exactly WIDTH edges, counter 0..WIDTH-1.
  - At the edge where counter==WIDTH-1, go to SIGN.
- SIGN
  - Apply sign correction.
  - Load hi/lo and div_zero.
  - Go to DONE.
- DONE
  - done=1 for exactly this cycle, busy=0.
  - Next edge: go to IDLE. start in DONE is ignored.

Latency and handshake:
- start accepted at edge E0 -> busy high from E0 to E33.
- hi/lo update and done rises at E33; done falls at E34.
- Fixed latency: 33 cycles, for all ops and operands.
- start while busy or in DONE is ignored; captured operands are unaffected by later changes on a/b/op.
- hi/lo hold their value outside the SIGN->DONE load.

Multiply:
- Shift-add on the 2W-bit accumulator, producing an unsigned 2W product of the magnitudes.
- Signed: negate the 2W result if sign(a)^sign(b).

Divide:
- Restoring divide of the magnitudes, producing quotient Q and remainder R.
- Signed: quotient negated if sign(a)^sign(b); remainder takes the sign of a (truncation toward zero).
- 0x80000000 / 0xFFFFFFFF (signed) -> lo=0x80000000, hi=0. No trap.

Divide by zero:
- Full latency still applies; div_zero=1.
- lo=0xFFFFFFFF, hi=a as captured. Identical for signed and unsigned.

Multiply ops always clear div_zero.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001, div_zero=0.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100/7 -> lo=14, hi=2; DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> done after 33 cycles; div_zero=1, lo=0xFFFFFFFF, hi=0x1234; a following MULTU 2x3 clears div_zero, lo=6.
- Handshake: pulse start again at cycle 5 of a busy MULTU with different a/b -> ignored; result matches the first operands; exactly one done pulse, and busy=0 in the done cycle.
- Reset: assert rst_n=0 mid-CALC, asynchronously between edges -> busy/hi/lo/done drop to 0 immediately; after release, a new DIVU 9/3 gives lo=3, hi=0 with normal latency.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit for the HI/LO instructions.
// One bit is resolved per clock; every operation takes the same 33 cycles
// from accepted start to the done pulse, regardless of op or operands.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t               state;
    logic [CW-1:0]        count;
    logic                 is_div;
    logic                 neg_q;     // quotient / product must be negated
    logic                 neg_r;     // remainder must be negated (sign of a)
    logic [WIDTH-1:0]     opnd;      // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0]   acc;       // {upper, lower}: product or {remainder, quotient}

    // Operand magnitudes; op[0] selects the signed variants.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    // The most negative value negates to itself, which is exactly its
    // unsigned magnitude, so no special case is needed.
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    // One iteration of shift-add multiply or restoring divide on acc.
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic [2*WIDTH-1:0]   acc_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        mul_sum  = '0;
        rem_sh   = '0;
        rem_diff = '0;
        acc_next = acc;
        if (!is_div) begin
            // Add the multiplicand into the upper half when the current
            // multiplier bit is set, then shift the whole 2W word right.
            mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                     + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            // Bring the next dividend bit into the partial remainder and
            // subtract the divisor when it fits.
            rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            rem_diff = rem_sh - {1'b0, opnd};
            if (rem_sh >= {1'b0, opnd})
                acc_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction of the finished magnitude result.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = neg_q ? (~acc + 1'b1) : acc;
        quot_fix = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            // NOTE: all state here updates with <= so every register samples
            // the pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= CALC;
                        busy     <= 1'b1;
                        count    <= '0;
                        is_div   <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= 1'b0;
                        if (op[1]) begin
                            opnd <= b_mag;
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == LAST_ITER)
                        state <= SIGN;
                end
                SIGN: begin
                    if (is_div) begin
                        // With a zero divisor every trial subtract succeeds,
                        // so the remainder ends as |a|; its sign fix-up
                        // restores a exactly. Only the quotient is forced.
                        hi       <= rem_fix;
                        lo       <= (opnd == '0) ? {WIDTH{1'b1}} : quot_fix;
                        div_zero <= (opnd == '0);
                    end else begin
                        {hi, lo} <= prod_fix;
                        div_zero <= 1'b0;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
